gate_truth_checker: RTL and testbench
=====================================

# gate_truth_checker

Self-checking stimulus/response engine for 2-input combinational gates. On `start` it drives all four input vectors `{a_out,b_out}` = 00, 01, 10, 11 into a gate under test and waits a fixed settle time for each. It samples the gate's output `y_in` and compares it against a parameterised truth table, then reports per-vector results and an overall pass/fail. It sits at the driving/observing end of a gate's interface and replaces hand-written monitor benches for the behavioural gate library.

## Interface
Parameters:
- `EXPECTED`, 4'b1110 (OR): truth table. Bit i is the expected `y_in` for vector i = {a,b}.
- `SETTLE_CYCLES`, 2: cycles each vector is held before sampling. Legal range ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a check run. Sampled in IDLE or DONE only.
- `y_in`  in  1  output of gate under test.
- `a_out`  out  1  gate input A.
- `b_out`  out  1  gate input B.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete. Level, held until next `start` or reset.
- `pass`  out  1  all 4 vectors matched. Valid only while `done`=1, else 0.
- `observed`  out  4  captured `y_in` per vector (bit i = vector i).
- `fail_mask`  out  4  bit i set if vector i mismatched.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - outputs at reset values.
  - `start`=1 → APPLY, with vec=0, settle count=0, `observed`/`fail_mask` cleared.
- APPLY:
  - `{a_out,b_out}` = vec.
  - Counts SETTLE_CYCLES cycles, then → SAMPLE.
- SAMPLE:
  - `{a_out,b_out}` still = vec.
  - At the end of the cycle, `observed[vec]` ← `y_in` and `fail_mask[vec]` ← (`y_in` !== `EXPECTED[vec]`). X/Z on `y_in` counts as a mismatch.
  - vec==3 → DONE. Otherwise vec+1 and → APPLY with the count reset.
- DONE:
  - `done`=1, `busy`=0, `pass` = (`fail_mask`==0).
  - `a_out`/`b_out` hold 11.
  - `start`=1 → restart exactly as from IDLE: results clear in the same edge and `done` drops.
- `start` during APPLY/SAMPLE is ignored. No abort input.
- vec is 2 bits. The settle counter is $clog2(SETTLE_CYCLES+1) bits and never wraps within a vector.
- Reset values (when `rst_n`=0 at a clock edge): state IDLE, `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `observed`=0, `fail_mask`=0.
- Reset mid-run: abandons the run with no partial `done`, and all of the above apply on that edge.
- `rst_n`=0 and `start`=1 on the same edge: reset wins.

## Timing
- All outputs are registered; none is combinationally dependent on inputs.
- `start` captured at edge E: `busy`=1 and vector 00 driven from E+1.
- Each vector occupies SETTLE_CYCLES+1 cycles (SETTLE_CYCLES APPLY + 1 SAMPLE). `y_in` is sampled at the last edge of that vector's window.
- Run length is 4·(SETTLE_CYCLES+1) cycles of `busy`. `done`/`pass` go valid at edge E+4·(SETTLE_CYCLES+1)+1. With the default: `busy` cycles 1–12, `done` from cycle 13.
- Vector changes occur at the edge after SAMPLE. `y_in` must settle within SETTLE_CYCLES cycles of a vector change.
- Back-to-back runs: `start` held high in DONE begins a new run at the next edge. The minimum gap between runs is 1 cycle of `done`.

## Structure
- Package `gate_chk_pkg`:
  - state enum (IDLE, APPLY, SAMPLE, DONE).
  - truth-table constants: TT_OR=4'b1110, TT_AND=4'b1000, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- One sub-module, `settle_timer`:
  - inputs: load, enable.
  - output: expired after SETTLE_CYCLES enabled cycles.
  - parameter SETTLE_CYCLES.
  - reset: synchronous active-low.
- Top: FSM, vector register, result registers.

## Test plan
- OR gate model, defaults, `start` pulse at cycle 0 → `a_out`/`b_out` sequence 00,01,10,11 (3 cycles each), `observed`=4'b1110, `fail_mask`=0, `pass`=1, `done` at cycle 13.
- Stuck-at-0 output with EXPECTED=TT_OR → `observed`=4'b0000, `fail_mask`=4'b1110, `pass`=0.
- AND gate model with EXPECTED=TT_OR → `fail_mask`=4'b0110, `pass`=0. Rerun via `start` in DONE with EXPECTED matched (TT_AND) → `pass`=1 and results cleared at the restart edge.
- `rst_n` low for 1 cycle during vector 10 → next cycle all outputs at reset values, state IDLE. A fresh `start` then completes normally.
- `start` pulsed repeatedly while `busy` → no effect on sequence or timing. SETTLE_CYCLES=1 → run length 8 cycles, `done` at cycle 9.
- `y_in` driven X on vector 01 → `fail_mask[1]`=1, `pass`=0.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker.
// Contents:
//   state_e        - FSM state encoding (IDLE, APPLY, SAMPLE, DONE)
//   TT_*           - truth tables for common 2-input gates; bit i is the
//                    expected output for input vector i = {a,b}
//   is_mismatch()  - compare one observed output bit against its expectation
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    // Case inequality so that an X or Z from the gate under test is a mismatch.
    function automatic logic is_mismatch(input logic observed, input logic expected);
        return (observed !== expected);
    endfunction

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// Settle timer for one test vector.
// Ports:
//   clk      in  clock, rising edge
//   rst_n    in  synchronous active-low reset
//   load     in  restart the count from zero
//   enable   in  count this cycle
//   expired  out high during the SETTLE_CYCLES-th enabled cycle, so the
//                owner can leave its wait state on that cycle's edge
// The counter saturates at SETTLE_CYCLES and never wraps.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear on load, otherwise advance while enabled up to the limit.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = {CW{1'b0}};
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives all four input vectors into a 2-input gate, samples its output
// after a settle time and compares against the EXPECTED truth table.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin a run (honoured only in IDLE or DONE)
//   y_in       in   output of the gate under test
//   a_out      out  gate input A
//   b_out      out  gate input B
//   busy       out  run in progress
//   done       out  run complete, held until next start or reset
//   pass       out  all four vectors matched (only while done)
//   observed   out  captured y_in per vector
//   fail_mask  out  bit i set if vector i mismatched
// All outputs come straight from flops; their next values are decoded from
// the next state so they change on the same edge as the FSM.
module gate_truth_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] EXPECTED      = TT_OR,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] observed,
    output logic [3:0] fail_mask
);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] observed_q, observed_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic [1:0] ab_q, ab_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic       timer_load_s;
    logic       timer_en_s;
    logic       timer_exp_s;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load_s),
        .enable (timer_en_s),
        .expired(timer_exp_s)
    );

    // Next-state, vector and result update.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        observed_d   = observed_q;
        fail_mask_d  = fail_mask_q;
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_APPLY;
                    vec_d        = 2'd0;
                    observed_d   = 4'b0000;
                    fail_mask_d  = 4'b0000;
                    timer_load_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_APPLY: begin
                timer_en_s = 1'b1;
                if (timer_exp_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_APPLY;
                end
            end
            ST_SAMPLE: begin
                observed_d[vec_q]  = y_in;
                fail_mask_d[vec_q] = is_mismatch(y_in, EXPECTED[vec_q]);
                timer_load_s       = 1'b1;
                if (vec_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    state_d = ST_APPLY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain flop.
    always_comb begin
        ab_d   = 2'b00;
        busy_d = 1'b0;
        done_d = 1'b0;
        pass_d = 1'b0;
        case (state_d)
            ST_APPLY, ST_SAMPLE: begin
                ab_d   = vec_d;
                busy_d = 1'b1;
            end
            ST_DONE: begin
                ab_d   = 2'b11;
                done_d = 1'b1;
                if (fail_mask_d == 4'b0000) begin
                    pass_d = 1'b1;
                end else begin
                    pass_d = 1'b0;
                end
            end
            default: begin
                ab_d = 2'b00;
            end
        endcase
    end

    // State, vector, result and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_q       <= 2'd0;
            observed_q  <= 4'b0000;
            fail_mask_q <= 4'b0000;
            ab_q        <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            observed_q  <= observed_d;
            fail_mask_q <= fail_mask_d;
            ab_q        <= ab_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign a_out     = ab_q[1];
    assign b_out     = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign observed  = observed_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker. Three checkers share clock, reset and start:
//   u_or  : EXPECTED=OR,  SETTLE_CYCLES=2
//   u_and : EXPECTED=AND, SETTLE_CYCLES=2
//   u_s1  : EXPECTED=OR,  SETTLE_CYCLES=1
// Each watches its own copy of a selectable gate model. A run-timeline model
// (cycle index within the run -> vector, sample points, results) predicts
// every output each cycle; directed literal checks pin that model.
module tb_gate_truth_checker;

    localparam int G_OR     = 0;
    localparam int G_AND    = 1;
    localparam int G_STUCK0 = 2;

    logic clk;
    logic rst_n;
    logic start;
    int   gate_sel;
    logic x_inj;
    logic chk_en;

    logic [2:0] a_w, b_w, busy_w, done_w, pass_w, y_w;
    logic [3:0] obs_w [3];
    logic [3:0] fm_w  [3];

    int         checks;
    int         failures;

    // Bench-side view of each instance's parameters.
    int         s_of   [3] = '{2, 2, 1};
    logic [3:0] exp_of [3] = '{4'b1110, 4'b1000, 4'b1110};

    // Timeline model state per instance.
    logic       m_run  [3];
    int         m_t    [3];
    logic       m_done [3];
    logic [3:0] m_obs  [3];
    logic [3:0] m_fm   [3];
    logic [2:0] y_hold;

    function automatic logic gate_y(input int sel, input logic xi, input logic a, input logic b);
        if (xi && !a && b) return 1'bx;
        case (sel)
            G_OR:    return a | b;
            G_AND:   return a & b;
            default: return 1'b0;
        endcase
    endfunction

    gate_truth_checker #(.EXPECTED(4'b1110), .SETTLE_CYCLES(2)) u_or (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_w[0]),
        .a_out(a_w[0]), .b_out(b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .observed(obs_w[0]), .fail_mask(fm_w[0]));

    gate_truth_checker #(.EXPECTED(4'b1000), .SETTLE_CYCLES(2)) u_and (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_w[1]),
        .a_out(a_w[1]), .b_out(b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .observed(obs_w[1]), .fail_mask(fm_w[1]));

    gate_truth_checker #(.EXPECTED(4'b1110), .SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_w[2]),
        .a_out(a_w[2]), .b_out(b_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .observed(obs_w[2]), .fail_mask(fm_w[2]));

    assign y_w[0] = gate_y(gate_sel, x_inj, a_w[0], b_w[0]);
    assign y_w[1] = gate_y(gate_sel, x_inj, a_w[1], b_w[1]);
    assign y_w[2] = gate_y(gate_sel, x_inj, a_w[2], b_w[2]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate output as seen mid-cycle, used by the model at the next edge.
    always @(negedge clk) y_hold <= y_w;

    // Run-timeline model: t counts cycles 1..4*(S+1) of a run; the last
    // cycle of each (S+1)-cycle window is where the gate output is captured.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_run[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_done[i] <= 1'b0;
                m_obs[i]  <= 4'b0000;
                m_fm[i]   <= 4'b0000;
            end else if (!m_run[i] && start) begin
                m_run[i]  <= 1'b1;
                m_t[i]    <= 1;
                m_done[i] <= 1'b0;
                m_obs[i]  <= 4'b0000;
                m_fm[i]   <= 4'b0000;
            end else if (m_run[i]) begin
                if ((m_t[i] % (s_of[i] + 1)) == 0) begin
                    m_obs[i][(m_t[i] - 1) / (s_of[i] + 1)] <= y_hold[i];
                    m_fm[i][(m_t[i] - 1) / (s_of[i] + 1)]  <=
                        (y_hold[i] !== exp_of[i][(m_t[i] - 1) / (s_of[i] + 1)]);
                end
                if (m_t[i] == 4 * (s_of[i] + 1)) begin
                    m_run[i]  <= 1'b0;
                    m_done[i] <= 1'b1;
                end else begin
                    m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    function automatic logic [12:0] model_out(input int i);
        int v;
        logic [1:0] ab;
        v = (m_t[i] - 1) / (s_of[i] + 1);
        if (m_run[i]) ab = 2'(v);
        else if (m_done[i]) ab = 2'b11;
        else ab = 2'b00;
        return {ab, m_run[i], m_done[i], m_done[i] && (m_fm[i] == 4'b0000), m_obs[i], m_fm[i]};
    endfunction

    function automatic logic [12:0] dut_out(input int i);
        return {a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], obs_w[i], fm_w[i]};
    endfunction

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    // Advance one cycle and compare every instance against the model.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_u%0d_t%0t", i, $time), dut_out(i), model_out(i));
            end
        end
    endtask

    // Start is sampled on the next edge; returns in cycle 1 of the run.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        gate_sel = G_OR;
        x_inj    = 1'b0;
        chk_en   = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_or",  dut_out(0), 13'd0);
        chk("reset_s1",  dut_out(2), 13'd0);
        rst_n = 1'b1;
        tick();

        // OR gate, defaults.
        pulse_start();
        chk("or_c1_ab_busy", 13'({a_w[0], b_w[0], busy_w[0]}), 13'(3'b001));
        repeat (3) tick();
        chk("or_c4_ab", 13'({a_w[0], b_w[0]}), 13'(2'b01));
        repeat (4) tick();
        chk("s1_c8_done", 13'(done_w[2]), 13'(1'b0));
        tick();
        chk("s1_c9_done", 13'(done_w[2]), 13'(1'b1));
        repeat (3) tick();
        chk("or_c12_busy_done", 13'({busy_w[0], done_w[0]}), 13'(2'b10));
        tick();
        chk("or_c13_result", 13'({done_w[0], pass_w[0], obs_w[0], fm_w[0]}), 13'(10'b11_1110_0000));
        chk("and_exp_or_gate", 13'({pass_w[1], fm_w[1]}), 13'(5'b0_0110));
        chk("or_done_ab", 13'({a_w[0], b_w[0], busy_w[0]}), 13'(3'b110));
        repeat (2) tick();

        // Stuck-at-0 gate.
        gate_sel = G_STUCK0;
        pulse_start();
        repeat (12) tick();
        chk("stuck0_or", 13'({pass_w[0], obs_w[0], fm_w[0]}), 13'(9'b0_0000_1110));
        repeat (2) tick();

        // AND gate, then restart from DONE.
        gate_sel = G_AND;
        pulse_start();
        repeat (12) tick();
        chk("and_gate_or_exp", 13'({pass_w[0], fm_w[0]}), 13'(5'b0_0110));
        chk("and_gate_and_exp", 13'({pass_w[1], obs_w[1], fm_w[1]}), 13'(9'b1_1000_0000));
        repeat (2) tick();
        pulse_start();
        chk("restart_clear", 13'({busy_w[1], done_w[1], obs_w[1], fm_w[1]}), 13'(10'b10_0000_0000));
        repeat (12) tick();
        chk("restart_pass", 13'({done_w[1], pass_w[1]}), 13'(2'b11));
        repeat (2) tick();

        // Reset during vector 10.
        gate_sel = G_OR;
        pulse_start();
        repeat (6) tick();
        chk("or_c7_ab", 13'({a_w[0], b_w[0]}), 13'(2'b10));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrun_reset", dut_out(0), 13'd0);
        repeat (2) tick();
        chk("after_reset_idle", dut_out(0), 13'd0);
        pulse_start();
        repeat (12) tick();
        chk("after_reset_run", 13'({done_w[0], pass_w[0]}), 13'(2'b11));
        repeat (2) tick();

        // Start toggling while busy is ignored.
        pulse_start();
        for (int k = 1; k <= 7; k++) begin
            start = (k % 2) == 1;
            tick();
        end
        start = 1'b0;
        repeat (4) tick();
        chk("busy_start_c12", 13'({busy_w[0], done_w[0]}), 13'(2'b10));
        tick();
        chk("busy_start_c13", 13'({done_w[0], pass_w[0]}), 13'(2'b11));
        repeat (2) tick();

        // Unknown gate output on vector 01.
        x_inj = 1'b1;
        pulse_start();
        repeat (12) tick();
        x_inj = 1'b0;
        chk("xinj_other_vecs", 13'({fm_w[0] & 4'b1101, obs_w[0][3]}), 13'(5'b0000_1));
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
